inst_sram_responder: RTL and testbench
======================================

Name: inst_sram_responder

Overview:
Responder (slave) end of the SRAM-like instruction bus: `inst_req`/`inst_addr`/`inst_addr_ok`/`inst_data_ok`/`inst_rdata`.
It accepts fetch requests, queues up to DEPTH outstanding addresses, and reads a 1-cycle-latency synchronous RAM. It returns data strictly in request order.
A per-request programmable extra delay lets the bench stress the fetch pipeline. It sits between the CPU fetch interface and on-chip instruction RAM.

Parameters:
RAM_AW, 14, RAM word-address width (RAM holds 2^RAM_AW 32-bit words)
DEPTH, 4, maximum outstanding accepted-but-unanswered requests (power of 2, >=2)
DLY_W, 4, width of the delay_i input

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
inst_req  input  1  initiator request valid
inst_addr  input  32  byte address; bits [1:0] ignored
inst_addr_ok  output  1  request accepted this cycle
inst_data_ok  output  1  read data valid this cycle
inst_rdata  output  32  read data
delay_i  input  DLY_W  extra wait cycles applied to the request at queue head
ram_en  output  1  RAM read enable
ram_addr  output  RAM_AW  RAM word address
ram_rdata  input  32  RAM data, valid the cycle after ram_en
busy  output  1  queue non-empty or response pending

Behaviour:
- Reset (async, resetn=0): queue empty (count=0), FSM=IDLE, wait counter=0. `inst_addr_ok`, `inst_data_ok`, `ram_en` and `busy` are all 0. Requests in flight are discarded and no `data_ok` is issued for them.
- `inst_addr_ok` = `inst_req` && (count < DEPTH). It is combinational from `inst_req` and registered count only; there is no path from this cycle's pop.
- Accept: on `inst_req` && `inst_addr_ok`, push `inst_addr`[RAM_AW+1:2]. Upper address bits are ignored, so addresses alias.
- Pop = `ram_en`. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: no response pending.
  - WAIT: counting down delay.
  - RESP: `inst_data_ok` cycle.
- Issue condition, "ready to start":
  - (state==IDLE or RESP) && count!=0.
  - If delay_i==0: `ram_en`=1 this cycle, next=RESP.
  - Else: load counter=delay_i, next=WAIT, no `ram_en`.
- WAIT: decrement the counter each cycle. When counter==1: `ram_en`=1, next=RESP.
- RESP:
  - `inst_data_ok`=1 and `inst_rdata`=`ram_rdata`.
  - If count==0 (after any pop), next=IDLE; otherwise apply the issue rule in the same cycle.
  - This gives 1 response/cycle throughput when delay_i==0.
- `ram_addr` = queue head whenever `ram_en`=1. Otherwise it holds the head value (don't-care).
- Latency: accept at cycle T means `data_ok` at T+2+delay_i, with delay_i sampled when the request reaches the issue point. A newly pushed entry is never issued in its push cycle.
- `inst_rdata` is meaningful only while `inst_data_ok`=1. There is no backpressure on `data_ok`, so the initiator must take it.
- `busy` = (count!=0) || (state!=IDLE).
- Full: with count==DEPTH, `addr_ok`=0 even if a pop occurs that cycle. `addr_ok` reasserts the next cycle.
- Empty: in IDLE with count==0, `ram_en`=0 and `data_ok`=0.
- Responses are returned strictly FIFO; there is no reordering and no cancellation. A cancelled fetch still receives its `data_ok`.

Decomposition:
- No new shared typedefs. FSM state encodings are localparams inside the block. Nothing is added to common.vh.
- One natural sub-module: `addr_queue`, a parameterised sync FIFO with width RAM_AW and depth DEPTH. It exposes push, pop, head, count, full and empty, with an async active-low reset on clk/resetn.

Test Plan:
- Single read, delay_i=0, RAM word 0x10 = 0xDEADBEEF: req `inst_addr`=0x40 at T -> `addr_ok` at T; `ram_en` with `ram_addr`=0x10 at T+1; `data_ok` with 0xDEADBEEF at T+2.
- Back-to-back, delay_i=0, addresses 0x0,0x4,0x8,0xC on consecutive cycles -> all accepted; `data_ok` on 4 consecutive cycles T+2..T+5 with words 0..3 in order.
- Full: delay_i=7, 5 consecutive requests with DEPTH=4 -> first 4 get `addr_ok`, the 5th sees `addr_ok`=0. It is accepted the cycle after the first `ram_en` (T+8); `data_ok` order is preserved.
- Delay: delay_i=3, single request at T -> `ram_en` at T+4, `data_ok` at T+5. Misaligned 0x43 reads the same word as 0x40.
- Reset mid-operation: 3 outstanding requests, pull resetn low mid-WAIT -> `addr_ok`/`data_ok`/`ram_en`/`busy` go 0 immediately. After release, no stale `data_ok` appears, and a new request completes at T+2.
- Simultaneous push/pop at count=2 -> count stays 2 and `busy` stays 1. Random req/delay_i run against a reference queue model -> all data matches, in order.

Source files
------------

// File: rtl/inst_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// inst_sram_responder_pkg
// Shared defaults for the instruction-bus responder slice.
//   RAM_AW_DEF : RAM word-address width (RAM holds 2^RAM_AW_DEF 32-bit words)
//   DEPTH_DEF  : maximum outstanding accepted-but-unanswered fetches
//   DLY_W_DEF  : width of the per-request extra-delay input
// No ports; imported by the responder top and its address queue.
// -----------------------------------------------------------------------------
package inst_sram_responder_pkg;

    localparam int RAM_AW_DEF = 14;
    localparam int DEPTH_DEF  = 4;
    localparam int DLY_W_DEF  = 4;

endpackage : inst_sram_responder_pkg

// File: rtl/inst_sram_responder_addr_queue.sv
// -----------------------------------------------------------------------------
// inst_sram_responder_addr_queue
// Synchronous FIFO that holds the RAM word addresses of accepted fetches
// until the responder issues them to the RAM.
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   push_i, data_i     enqueue one word address (ignored when full)
//   pop_i              dequeue the head entry (ignored when empty)
//   head_o             current head entry
//   count_o            number of stored entries (0..DEPTH)
//   full_o, empty_o    count_o == DEPTH / count_o == 0
// -----------------------------------------------------------------------------
module inst_sram_responder_addr_queue
    import inst_sram_responder_pkg::*;
#(
    parameter int WIDTH = RAM_AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two
    // makes them wrap on their own.  A simultaneous push and pop leaves the
    // count untouched.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : inst_sram_responder_addr_queue

// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
// Responder end of the SRAM-like instruction bus.  Accepts fetch requests,
// queues up to DEPTH outstanding word addresses, reads a 1-cycle-latency
// synchronous RAM and returns data strictly in request order.  Each request
// may be held back by delay_i extra cycles, sampled when it reaches the
// issue point.
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   inst_req, inst_addr           fetch request and byte address
//   inst_addr_ok                  request accepted this cycle
//   inst_data_ok, inst_rdata      response strobe and data
//   delay_i                       extra wait cycles for the queue head
//   ram_en, ram_addr, ram_rdata   synchronous RAM read port
//   busy                          work queued or a response pending
// -----------------------------------------------------------------------------
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DLY_W  = DLY_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic [DLY_W-1:0]  delay_i,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic              issue;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic [RAM_AW-1:0] q_head;
    logic [$clog2(DEPTH):0] q_count;
    logic              unused_bits;

    // Only the word-address bits reach the RAM; the rest alias.
    assign unused_bits = ^{inst_addr[31:RAM_AW+2], inst_addr[1:0], q_count};

    // Acceptance depends only on the request and the registered fill level,
    // so a pop in the same cycle cannot re-open a full queue.
    assign inst_addr_ok = inst_req && resetn && !q_full;
    assign push         = inst_req && inst_addr_ok;

    inst_sram_responder_addr_queue #(
        .WIDTH (RAM_AW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .data_i  (inst_addr[RAM_AW+1:2]),
        .pop_i   (ram_en),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign ram_addr   = q_head;
    assign inst_rdata = ram_rdata;
    assign busy       = !q_empty || (state_q != ST_IDLE);

    // RESP doubles as an issue slot so back-to-back zero-delay requests
    // stream at one response per cycle.  q_empty is registered, so an entry
    // pushed this cycle is never issued in its push cycle.
    always_comb begin
        state_d      = state_q;
        dly_cnt_d    = dly_cnt_q;
        ram_en       = 1'b0;
        inst_data_ok = 1'b0;
        issue        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue = !q_empty;
            end
            ST_WAIT: begin
                dly_cnt_d = dly_cnt_q - DLY_W'(1);
                if (dly_cnt_q == DLY_W'(1)) begin
                    ram_en  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                inst_data_ok = 1'b1;
                if (q_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    issue = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (issue) begin
            if (delay_i == '0) begin
                ram_en  = 1'b1;
                state_d = ST_RESP;
            end else begin
                dly_cnt_d = delay_i;
                state_d   = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            dly_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
        end
    end

endmodule : inst_sram_responder

// File: tb/tb_inst_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_responder
// Directed bench for inst_sram_responder with a behavioural 1-cycle RAM and
// an in-order reference queue that checks every returned word.
// -----------------------------------------------------------------------------
module tb_inst_sram_responder;

    localparam int RAM_AW = 14;
    localparam int DEPTH  = 4;
    localparam int DLY_W  = 4;

    logic              clk;
    logic              resetn;
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    logic [DLY_W-1:0]  delay_i;
    logic              ram_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_rdata;
    logic              busy;

    int checks;
    int failures;
    int rsp_cnt;
    logic [RAM_AW-1:0] exp_q[$];

    inst_sram_responder #(
        .RAM_AW (RAM_AW),
        .DEPTH  (DEPTH),
        .DLY_W  (DLY_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .delay_i      (delay_i),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_rdata    (ram_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents are a fixed function of the word address, with the
    // well-known word at 0x10.
    function automatic logic [31:0] memWord(input logic [RAM_AW-1:0] a);
        if (a == 14'h10) return 32'hDEADBEEF;
        return {16'hC0DE, 2'b00, a};
    endfunction

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= memWord(ram_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic [DLY_W-1:0] dly);
        inst_req  = req;
        inst_addr = addr;
        delay_i   = dly;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input int max_cycles, input string tag);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Reference queue: every accepted address must come back, in order,
    // with the word the RAM holds at that address.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
        end else begin
            if (inst_data_ok) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("stale_data_ok", 32'(inst_data_ok), 32'd0);
                end else begin
                    logic [RAM_AW-1:0] a;
                    a = exp_q.pop_front();
                    checkOutput($sformatf("rdata_w%0h", a), inst_rdata, memWord(a));
                end
            end
            if (inst_req && inst_addr_ok) exp_q.push_back(inst_addr[RAM_AW+1:2]);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int snap;
        checks    = 0;
        failures  = 0;
        rsp_cnt   = 0;
        resetn    = 1'b0;
        applyStimulus(1'b0, 32'h0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
        checkOutput("rst_data_ok", 32'(inst_data_ok), 32'd0);
        checkOutput("rst_ram_en",  32'(ram_en),       32'd0);
        checkOutput("rst_busy",    32'(busy),         32'd0);
        resetn = 1'b1;
        tick();

        // Single read, zero delay
        $display("[TB] single read");
        applyStimulus(1'b1, 32'h40, 4'd0);
        @(negedge clk);
        checkOutput("t1_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        checkOutput("t1_ram_en",   32'(ram_en),       32'd1);
        checkOutput("t1_ram_addr", 32'(ram_addr),     32'h10);
        checkOutput("t1_early_ok", 32'(inst_data_ok), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("t1_data_ok", 32'(inst_data_ok), 32'd1);
        checkOutput("t1_rdata",   inst_rdata,        32'hDEADBEEF);
        tick();
        @(negedge clk);
        checkOutput("t1_done_ok",   32'(inst_data_ok), 32'd0);
        checkOutput("t1_done_busy", 32'(busy),         32'd0);
        tick();

        // Back-to-back, one response per cycle
        $display("[TB] back-to-back");
        for (int i = 0; i < 7; i++) begin
            if (i < 4) applyStimulus(1'b1, 32'(i * 4), 4'd0);
            else       applyStimulus(1'b0, 32'h0, 4'd0);
            @(negedge clk);
            if (i < 4) checkOutput($sformatf("b2b_addr_ok%0d", i), 32'(inst_addr_ok), 32'd1);
            if (i >= 2 && i < 6) begin
                checkOutput($sformatf("b2b_data_ok%0d", i), 32'(inst_data_ok), 32'd1);
                checkOutput($sformatf("b2b_rdata%0d", i), inst_rdata,
                            memWord(RAM_AW'(i - 2)));
            end
            if (i == 6) checkOutput("b2b_tail_ok", 32'(inst_data_ok), 32'd0);
            tick();
        end

        // Full queue with delay 7
        $display("[TB] full queue");
        snap = rsp_cnt;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (k < 5) applyStimulus(1'b1, 32'h100 + 32'(k * 4), 4'd7);
            else       applyStimulus(1'b0, 32'h0, 4'd7);
            @(negedge clk);
            if (i < 4)  checkOutput($sformatf("full_addr_ok%0d", i), 32'(inst_addr_ok), 32'd1);
            if (i == 4) checkOutput("full_reject",  32'(inst_addr_ok), 32'd0);
            if (i == 7) checkOutput("full_no_en",   32'(ram_en),       32'd0);
            if (i == 8) begin
                checkOutput("full_first_en",  32'(ram_en),       32'd1);
                checkOutput("full_pop_reject", 32'(inst_addr_ok), 32'd0);
            end
            if (i == 9) checkOutput("full_reaccept", 32'(inst_addr_ok), 32'd1);
            if (inst_req && inst_addr_ok) k++;
            tick();
        end
        applyStimulus(1'b0, 32'h0, 4'd0);
        waitIdle(200, "full");
        checkOutput("full_rsp_cnt", 32'(rsp_cnt - snap), 32'd5);

        // Delay 3 with a misaligned address
        $display("[TB] delayed read");
        applyStimulus(1'b1, 32'h43, 4'd3);
        @(negedge clk);
        checkOutput("dly_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 4'd3);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 4) checkOutput($sformatf("dly_no_en%0d", i), 32'(ram_en), 32'd0);
            if (i == 4) begin
                checkOutput("dly_ram_en",   32'(ram_en),   32'd1);
                checkOutput("dly_ram_addr", 32'(ram_addr), 32'h10);
            end
            if (i == 5) begin
                checkOutput("dly_data_ok", 32'(inst_data_ok), 32'd1);
                checkOutput("dly_rdata",   inst_rdata,        32'hDEADBEEF);
            end
            tick();
        end
        waitIdle(50, "dly");

        // Simultaneous push and pop at count 2
        $display("[TB] push/pop at count 2");
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      applyStimulus(1'b1, 32'h200, 4'd2);
            else if (i == 1) applyStimulus(1'b1, 32'h204, 4'd2);
            else if (i == 3) applyStimulus(1'b1, 32'h208, 4'd2);
            else             applyStimulus(1'b0, 32'h0,   4'd2);
            @(negedge clk);
            if (i == 2) checkOutput("pp_count_pre", 32'(dut.u_queue.count_o), 32'd2);
            if (i == 3) begin
                checkOutput("pp_ram_en",  32'(ram_en),       32'd1);
                checkOutput("pp_addr_ok", 32'(inst_addr_ok), 32'd1);
            end
            if (i == 4) begin
                checkOutput("pp_count_post", 32'(dut.u_queue.count_o), 32'd2);
                checkOutput("pp_busy",       32'(busy),               32'd1);
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 4'd0);
        waitIdle(100, "pp");

        // Reset in the middle of a wait
        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i * 4), 4'd5);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 4'd5);
        @(negedge clk);
        checkOutput("mid_busy_pre", 32'(busy), 32'd1);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("mid_addr_ok", 32'(inst_addr_ok), 32'd0);
        checkOutput("mid_data_ok", 32'(inst_data_ok), 32'd0);
        checkOutput("mid_ram_en",  32'(ram_en),       32'd0);
        checkOutput("mid_busy",    32'(busy),         32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'd0);
        snap = rsp_cnt;
        repeat (10) tick();
        checkOutput("mid_no_stale", 32'(rsp_cnt - snap), 32'd0);
        applyStimulus(1'b1, 32'h40, 4'd0);
        @(negedge clk);
        checkOutput("mid_new_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 4'd0);
        tick();
        @(negedge clk);
        checkOutput("mid_new_data_ok", 32'(inst_data_ok), 32'd1);
        checkOutput("mid_new_rdata",   inst_rdata,        32'hDEADBEEF);
        tick();

        // Random traffic against the reference queue
        $display("[TB] random traffic");
        snap = rsp_cnt;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, DLY_W'($urandom_range(0, 3)));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 4'd0);
        waitIdle(200, "rand");
        checkOutput("rand_some_rsp", 32'(rsp_cnt - snap > 20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_sram_responder
